// File: rtl/uart_pkg.sv
// Shared UART constants: oversample defaults and baud divisors for a 100 MHz clock.
// Divisors are in clk cycles per oversample tick, given as integer + fraction/16.
package uart_pkg;

    localparam int OVS_DEF    = 16;
    localparam int OVS_W      = $clog2(OVS_DEF);
    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;

    // 100e6 / (16 * baud), fractional part expressed in 1/16 cycle units
    localparam int BAUD_9600_INT    = 651;
    localparam int BAUD_9600_FRAC   = 1;
    localparam int BAUD_115200_INT  = 54;
    localparam int BAUD_115200_FRAC = 4;
    localparam int BAUD_230400_INT  = 27;
    localparam int BAUD_230400_FRAC = 2;

    // Average oversample period in 1/2^FRAC_W_DEF cycle units, handy for rate checks.
    function automatic int unsigned baud_period_fx(input int unsigned div_i,
                                                   input int unsigned div_f);
        return (div_i << FRAC_W_DEF) + div_f;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: adds the fraction once per period reload and
// reports the wrap-around carry, which stretches that period by one clock.
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_step,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] w_sum;

    // Carry is combinational so the period being loaded this cycle can include it
    always_comb begin
        {o_carry, w_sum} = {1'b0, r_acc} + {1'b0, i_frac};
    end

    // Accumulator advances only on a reload; clear restarts the fractional phase
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick source: divides clk by a programmable integer+fractional divisor to
// give an oversample tick, and every OVERSAMPLE oversample ticks a bit tick.
// All outputs come straight from flops; the next-state logic looks one cycle ahead.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF,
    parameter int OVERSAMPLE = OVS_DEF,
    parameter int RST_DIV    = BAUD_230400_INT,
    parameter int RST_FRAC   = BAUD_230400_FRAC,
    // FRAC_W = 0 still needs a 1-bit vector; its value is forced to zero inside
    localparam int FRAC_WI   = (FRAC_W > 0) ? FRAC_W : 1,
    localparam int PH_W      = $clog2(OVERSAMPLE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DIV_W-1:0]   div_int,
    input  logic [FRAC_WI-1:0] div_frac,
    input  logic               div_load,
    input  logic               resync,
    output logic               tick_os,
    output logic               tick_bit,
    output logic [PH_W-1:0]    os_phase
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);

    // Shadow divisor
    logic [DIV_W-1:0]   r_div_int;
    logic [FRAC_WI-1:0] r_div_frac;

    // Counter / phase state and registered outputs
    logic [DIV_W-1:0]   r_cnt;
    logic               r_run;
    logic [PH_W-1:0]    r_phase;
    logic               r_tick_os;
    logic               r_tick_bit;

    // Next-state signals
    logic [DIV_W-1:0]   w_d;
    logic [DIV_W-1:0]   w_d_m1;
    logic [DIV_W-1:0]   w_p_m1;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [PH_W-1:0]    w_phase_nxt;
    logic [FRAC_WI-1:0] w_frac;
    logic               w_carry;
    logic               w_reload;
    logic               w_clr_acc;
    logic               w_tick_nxt;
    logic               w_bit_nxt;

    baud_frac_acc #(
        .FRAC_W (FRAC_WI)
    ) u_frac_acc (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr_acc),
        .i_step  (w_reload),
        .i_frac  (w_frac),
        .o_carry (w_carry)
    );

    // Period arithmetic: D = max(shadow, 1), reload value P-1 = D-1+carry (never overflows)
    always_comb begin
        w_frac = (FRAC_W > 0) ? r_div_frac : '0;
        w_d    = (r_div_int == '0) ? DIV_ONE : r_div_int;
        w_d_m1 = w_d - DIV_ONE;
        w_p_m1 = w_d_m1 + DIV_W'(w_carry);
    end

    // Next counter/phase/tick values; a tick is issued for the cycle in which cnt reaches 0.
    // The first enabled cycle (r_run=0) acts as a reload without a tick, so the first
    // tick lands exactly P cycles after enable rises.
    always_comb begin
        w_reload    = 1'b0;
        w_clr_acc   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_tick_nxt  = 1'b0;
        w_bit_nxt   = 1'b0;
        if (!enable) begin
            w_clr_acc   = 1'b1;
            w_cnt_nxt   = '0;
            w_phase_nxt = '0;
        end else if (resync) begin
            // Restart half a bit in; the pending tick, if any, is dropped
            w_clr_acc   = 1'b1;
            w_cnt_nxt   = w_d_m1;
            w_phase_nxt = PH_MID;
        end else begin
            w_reload   = !r_run || (r_cnt == '0);
            w_cnt_nxt  = w_reload ? w_p_m1 : (r_cnt - DIV_ONE);
            w_tick_nxt = (w_cnt_nxt == '0);
            if (w_tick_nxt) begin
                w_phase_nxt = r_phase + PH_ONE;
            end
            w_bit_nxt = w_tick_nxt && (w_phase_nxt == '0);
        end
    end

    // Shadow divisor capture; takes effect at the next period reload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_int  <= DIV_W'(RST_DIV);
            r_div_frac <= FRAC_WI'(RST_FRAC);
        end else if (div_load) begin
            r_div_int  <= div_int;
            r_div_frac <= div_frac;
        end
    end

    // Counter, phase and output tick registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_run      <= 1'b0;
            r_phase    <= '0;
            r_tick_os  <= 1'b0;
            r_tick_bit <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_run      <= enable;
            r_phase    <= w_phase_nxt;
            r_tick_os  <= w_tick_nxt;
            r_tick_bit <= w_bit_nxt;
        end
    end

    assign tick_os  = r_tick_os;
    assign tick_bit = r_tick_bit;
    assign os_phase = r_phase;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with hand-computed tick times.
// Cycle numbering: after start_run, cycle 1 is the first clock edge that sees enable=1.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        resync;
    logic        tick_os;
    logic        tick_bit;
    logic [3:0]  os_phase;

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_orphan = 0;
    int q_os[$];
    int q_bit[$];
    int prev_sz;

    always #5 clk = ~clk;

    baud_tick_gen #(
        .DIV_W      (16),
        .FRAC_W     (4),
        .OVERSAMPLE (16),
        .RST_DIV    (27),
        .RST_FRAC   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .resync   (resync),
        .tick_os  (tick_os),
        .tick_bit (tick_bit),
        .os_phase (os_phase)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance k clocks, sampling 1 time unit after each rising edge
    task automatic step_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (tick_os === 1'b1) q_os.push_back(cyc);
            if (tick_bit === 1'b1) begin
                q_bit.push_back(cyc);
                if (tick_os !== 1'b1) n_orphan++;
            end
        end
    endtask

    // Disable, load a divisor, then enable with cycle count and logs cleared
    task automatic start_run(input logic [15:0] d, input logic [3:0] f);
        enable   = 1'b0;
        div_int  = d;
        div_frac = f;
        div_load = 1'b1;
        step_cycles(1);
        div_load = 1'b0;
        step_cycles(1);
        enable = 1'b1;
        cyc    = 0;
        q_os.delete();
        q_bit.delete();
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        resync   = 1'b0;
        step_cycles(3);
        check_val("rst_tick_os", tick_os, 0);
        check_val("rst_tick_bit", tick_bit, 0);
        check_val("rst_os_phase", os_phase, 0);
        rst = 1'b0;

        // D=4, frac=0: ticks at 4,8,..; tick_bit every 64
        start_run(16'd4, 4'd0);
        step_cycles(134);
        check_val("d4_n_os", q_os.size(), 33);
        check_val("d4_os0", q_os[0], 4);
        check_val("d4_os1", q_os[1], 8);
        check_val("d4_n_bit", q_bit.size(), 2);
        check_val("d4_bit0", q_bit[0], 64);
        check_val("d4_bit1", q_bit[1], 128);
        check_val("d4_phase", os_phase, 1);

        // D=4, frac=8/16: periods 4,5,4,5..; 32 ticks in 144 clk
        start_run(16'd4, 4'd8);
        step_cycles(144);
        check_val("f8_n_os", q_os.size(), 32);
        check_val("f8_os0", q_os[0], 4);
        check_val("f8_os1", q_os[1], 9);
        check_val("f8_os2", q_os[2], 13);
        check_val("f8_os31", q_os[31], 144);
        check_val("f8_bit0", q_bit[0], 72);
        check_val("f8_bit1", q_bit[1], 144);

        // D=0 behaves as D=1: tick every clk, tick_bit every 16
        start_run(16'd0, 4'd0);
        step_cycles(32);
        check_val("d0_n_os", q_os.size(), 32);
        check_val("d0_os0", q_os[0], 1);
        check_val("d0_bit0", q_bit[0], 16);
        check_val("d0_bit1", q_bit[1], 32);
        start_run(16'd1, 4'd0);
        step_cycles(32);
        check_val("d1_n_os", q_os.size(), 32);
        check_val("d1_bit0", q_bit[0], 16);
        check_val("d1_bit1", q_bit[1], 32);

        // D=10 running, load D=3 mid-period: 10,20 then 23,26
        start_run(16'd10, 4'd0);
        step_cycles(15);
        div_int  = 16'd3;
        div_load = 1'b1;
        step_cycles(1);
        div_load = 1'b0;
        step_cycles(11);
        check_val("ld_n_os", q_os.size(), 4);
        check_val("ld_os1", q_os[1], 20);
        check_val("ld_os2", q_os[2], 23);
        check_val("ld_os3", q_os[3], 26);

        // resync at os_phase=3 with D=4
        start_run(16'd4, 4'd0);
        step_cycles(13);
        check_val("rs_phase_before", os_phase, 3);
        resync = 1'b1;
        step_cycles(1);
        resync = 1'b0;
        check_val("rs_phase_after", os_phase, 8);
        check_val("rs_tick_after", tick_os, 0);
        step_cycles(31);
        check_val("rs_os3", q_os[3], 17);
        check_val("rs_n_bit", q_bit.size(), 1);
        check_val("rs_bit0", q_bit[0], 45);
        check_val("rs_phase_end", os_phase, 0);

        // enable=0 clears and stops; resync while disabled is ignored
        step_cycles(2);
        enable = 1'b0;
        step_cycles(1);
        check_val("dis_phase", os_phase, 0);
        check_val("dis_tick", tick_os, 0);
        prev_sz = q_os.size();
        resync  = 1'b1;
        step_cycles(1);
        resync  = 1'b0;
        check_val("dis_resync_phase", os_phase, 0);
        step_cycles(20);
        check_val("dis_no_ticks", q_os.size(), prev_sz);

        // rst mid-run on a would-be tick, then restart with the 27/2 reset divisor
        start_run(16'd5, 4'd0);
        step_cycles(9);
        rst = 1'b1;
        step_cycles(1);
        check_val("mrst_tick", tick_os, 0);
        check_val("mrst_phase", os_phase, 0);
        rst = 1'b0;
        cyc = 0;
        q_os.delete();
        q_bit.delete();
        step_cycles(54);
        check_val("mrst_n_os", q_os.size(), 2);
        check_val("mrst_os0", q_os[0], 27);
        check_val("mrst_os1", q_os[1], 54);

        check_val("bit_without_os", n_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
